// File: rtl/dmem_timer_resp.sv
// dmem_timer_resp: memory-mapped timer answering the data-memory SRAM port.
// Prescaled 32-bit up-counter with compare, auto-reload, sticky MATCH/OVF
// status flags and a level interrupt. Only addr0[2:0] is decoded.
module dmem_timer_resp #(
    parameter int ADDR_WIDTH  = 6,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [3:0]            wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [31:0]           din0,
    output logic [31:0]           dout0,
    output logic                  irq
);

    localparam logic [2:0]  REG_CTRL    = 3'd0;
    localparam logic [2:0]  REG_STATUS  = 3'd1;
    localparam logic [2:0]  REG_COUNT   = 3'd2;
    localparam logic [2:0]  REG_COMPARE = 3'd3;
    localparam logic [2:0]  REG_ID      = 3'd4;
    localparam logic [31:0] ID_VALUE    = 32'h54494D31;
    localparam logic [31:0] COUNT_MAX   = 32'hFFFFFFFF;

    // Architectural state
    logic                   en;
    logic                   autoreload;
    logic                   irqen;
    logic [PRESC_WIDTH-1:0] presc;
    logic [PRESC_WIDTH-1:0] pcnt;
    logic                   match;
    logic                   ovf;
    logic [31:0]            count;
    logic [31:0]            compare;

    // Next-state values
    logic                   en_n;
    logic                   autoreload_n;
    logic                   irqen_n;
    logic [PRESC_WIDTH-1:0] presc_n;
    logic [PRESC_WIDTH-1:0] pcnt_n;
    logic                   match_n;
    logic                   ovf_n;
    logic [31:0]            count_n;
    logic [31:0]            compare_n;

    // Access decode
    logic        acc_wr;
    logic        acc_rd;
    logic [2:0]  reg_sel;
    logic [3:0]  byte_en;
    logic [31:0] ctrl_word;
    logic [31:0] ctrl_wdata;
    logic [31:0] rd_data;
    logic        tick;
    logic        set_match;
    logic        set_ovf;
    logic [1:0]  clr_flags;
    logic        unused_addr;

    // Upper address bits are routed to the decoder elsewhere; ignored here.
    assign unused_addr = ^addr0[ADDR_WIDTH-1:3];

    assign acc_wr  = !csb0 && !web0;
    assign acc_rd  = !csb0 &&  web0;
    assign reg_sel = addr0[2:0];
    assign byte_en = (wmask0 == 4'b0000) ? 4'b1111 : wmask0;

    assign ctrl_word = {16'h0000, 8'(presc), 5'b00000, irqen, autoreload, en};

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] wdat,
        input logic [3:0]  ben
    );
        logic [31:0] r;
        r = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (ben[i]) begin
                r[8*i +: 8] = wdat[8*i +: 8];
            end
        end
        return r;
    endfunction

    assign ctrl_wdata = byte_merge(ctrl_word, din0, byte_en);

    // Read mux: pre-edge register contents
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CTRL:    rd_data = ctrl_word;
            REG_STATUS:  rd_data = {30'b0, ovf, match};
            REG_COUNT:   rd_data = count;
            REG_COMPARE: rd_data = compare;
            REG_ID:      rd_data = ID_VALUE;
            default:     rd_data = '0;
        endcase
    end

    // Prescaler: tick when pcnt reaches PRESC while enabled
    always_comb begin
        tick   = en && (pcnt == presc);
        pcnt_n = '0;
        if (en && !tick) begin
            // A PRESC written below pcnt lets pcnt run up and wrap naturally.
            pcnt_n = pcnt + 1'b1;
        end
        if (acc_wr && reg_sel == REG_CTRL && !ctrl_wdata[0]) begin
            pcnt_n = '0;
        end
    end

    // Counter, compare and flag next-state; software writes win over the tick
    always_comb begin
        en_n         = en;
        autoreload_n = autoreload;
        irqen_n      = irqen;
        presc_n      = presc;
        count_n      = count;
        compare_n    = compare;
        set_match    = 1'b0;
        set_ovf      = 1'b0;
        clr_flags    = 2'b00;

        if (tick) begin
            if (count == compare) begin
                set_match = 1'b1;
                set_ovf   = (count == COUNT_MAX);
                count_n   = autoreload ? '0 : count + 32'd1;
            end else if (count == COUNT_MAX) begin
                set_ovf = 1'b1;
                count_n = '0;
            end else begin
                count_n = count + 32'd1;
            end
        end

        if (acc_wr) begin
            case (reg_sel)
                REG_CTRL: begin
                    en_n         = ctrl_wdata[0];
                    autoreload_n = ctrl_wdata[1];
                    irqen_n      = ctrl_wdata[2];
                    presc_n      = PRESC_WIDTH'(ctrl_wdata[15:8]);
                end
                REG_STATUS: begin
                    if (byte_en[0]) begin
                        clr_flags = din0[1:0];
                    end
                end
                REG_COUNT:   count_n   = byte_merge(count, din0, byte_en);
                REG_COMPARE: compare_n = byte_merge(compare, din0, byte_en);
                default: ;
            endcase
        end

        // Hardware set takes priority over a same-edge W1C clear.
        match_n = (match & ~clr_flags[0]) | set_match;
        ovf_n   = (ovf   & ~clr_flags[1]) | set_ovf;
    end

    // State registers and interrupt (irq follows next-state flags)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en         <= 1'b0;
            autoreload <= 1'b0;
            irqen      <= 1'b0;
            presc      <= '0;
            pcnt       <= '0;
            match      <= 1'b0;
            ovf        <= 1'b0;
            count      <= '0;
            compare    <= '1;
            irq        <= 1'b0;
        end else begin
            en         <= en_n;
            autoreload <= autoreload_n;
            irqen      <= irqen_n;
            presc      <= presc_n;
            pcnt       <= pcnt_n;
            match      <= match_n;
            ovf        <= ovf_n;
            count      <= count_n;
            compare    <= compare_n;
            irq        <= irqen_n & (match_n | ovf_n);
        end
    end

    // Registered read data; holds when idle or writing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout0 <= '0;
        end else if (acc_rd) begin
            dout0 <= rd_data;
        end
    end

endmodule

// File: tb/tb_dmem_timer_resp.sv
// Self-checking bench for dmem_timer_resp: directed scenarios followed by
// random register traffic, all compared against a behavioural model.
module tb_dmem_timer_resp;

    logic        clk;
    logic        rst_n;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [5:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: registers held as whole words / plain integers
    logic [31:0] m_ctrl;
    logic        m_match;
    logic        m_ovf;
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    int          m_pcnt;
    logic [31:0] m_dout;
    logic        m_irq;

    dmem_timer_resp #(
        .ADDR_WIDTH (6),
        .PRESC_WIDTH(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .csb0  (csb0),
        .web0  (web0),
        .wmask0(wmask0),
        .addr0 (addr0),
        .din0  (din0),
        .dout0 (dout0),
        .irq   (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl  = 32'h0;
        m_match = 1'b0;
        m_ovf   = 1'b0;
        m_count = 32'h0;
        m_cmp   = 32'hFFFFFFFF;
        m_pcnt  = 0;
        m_dout  = 32'h0;
        m_irq   = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_ctrl;
            3'd1:    return {30'b0, m_ovf, m_match};
            3'd2:    return m_count;
            3'd3:    return m_cmp;
            3'd4:    return 32'h54494D31;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step(input logic c, input logic w, input logic [3:0] m,
                              input logic [2:0] a, input logic [31:0] d);
        logic [31:0] rd, bm, nctrl, ncount, ncmp;
        logic        nmatch, novf, smatch, sovf;
        logic [1:0]  clr;
        int          npcnt, presc;
        bit          en, tick;

        rd    = m_read(a);
        bm    = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (m == 4'b0000 || m[i]) bm[8*i +: 8] = 8'hFF;
        end
        en    = m_ctrl[0];
        presc = int'(m_ctrl[15:8]);
        tick  = en && (m_pcnt == presc);
        npcnt = (!en || tick) ? 0 : (m_pcnt + 1) % 256;

        nctrl  = m_ctrl;
        ncount = m_count;
        ncmp   = m_cmp;
        smatch = 1'b0;
        sovf   = 1'b0;
        clr    = 2'b00;

        if (tick) begin
            if (m_count == m_cmp) begin
                smatch = 1'b1;
                if (m_count == 32'hFFFFFFFF) sovf = 1'b1;
                ncount = m_ctrl[1] ? 32'h0 : 32'((64'(m_count) + 1) % 64'h1_0000_0000);
            end else if (m_count == 32'hFFFFFFFF) begin
                sovf   = 1'b1;
                ncount = 32'h0;
            end else begin
                ncount = m_count + 32'd1;
            end
        end

        if (!c && !w) begin
            case (a)
                3'd0: begin
                    nctrl = ((m_ctrl & ~bm) | (d & bm)) & 32'h0000FF07;
                    if (!nctrl[0]) npcnt = 0;
                end
                3'd1: if (bm[0]) clr = d[1:0];
                3'd2: ncount = (m_count & ~bm) | (d & bm);
                3'd3: ncmp   = (m_cmp & ~bm) | (d & bm);
                default: ;
            endcase
        end

        nmatch = (m_match && !clr[0]) || smatch;
        novf   = (m_ovf && !clr[1]) || sovf;

        if (!c && w) m_dout = rd;
        m_ctrl  = nctrl;
        m_count = ncount;
        m_cmp   = ncmp;
        m_match = nmatch;
        m_ovf   = novf;
        m_pcnt  = npcnt;
        m_irq   = nctrl[2] && (nmatch || novf);
    endtask

    // One clock of port activity; outputs sampled 1 time unit after the edge.
    task automatic access(input logic c, input logic w, input logic [3:0] m,
                          input logic [2:0] a, input logic [31:0] d);
        csb0   = c;
        web0   = w;
        wmask0 = m;
        addr0  = {3'b000, a};
        din0   = d;
        @(posedge clk);
        #1;
        model_step(c, w, m, a, d);
        check("dout0", dout0, m_dout);
        check("irq", {31'b0, irq}, {31'b0, m_irq});
        csb0 = 1'b1;
        web0 = 1'b1;
    endtask

    task automatic idle();
        access(1'b1, 1'b1, 4'b0000, 3'd0, 32'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        access(1'b0, 1'b0, 4'b0000, a, d);
    endtask

    task automatic wrm(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
        access(1'b0, 1'b0, m, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        access(1'b0, 1'b1, 4'b0000, a, 32'h0);
    endtask

    initial begin
        logic        c, w;
        logic [3:0]  m;
        logic [2:0]  a;
        logic [31:0] d;
        bit          seen;

        rst_n  = 1'b1;
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = 4'b0000;
        addr0  = '0;
        din0   = '0;
        model_reset();

        // Reset and identification
        #3 rst_n = 1'b0;
        #20;
        check("reset_dout", dout0, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        #4 rst_n = 1'b1;
        rd(3'd4); check("id", dout0, 32'h54494D31);
        rd(3'd3); check("compare_reset", dout0, 32'hFFFFFFFF);
        rd(3'd6); check("reserved_read", dout0, 32'h0);
        rd(3'd0); check("ctrl_reset", dout0, 32'h0);

        // Prescaled count: PRESC=3 gives one tick per 4 cycles
        wr(3'd0, 32'h00000301);
        for (int i = 0; i < 40; i++) idle();
        rd(3'd2); check("presc_count", dout0, 32'd10);
        wr(3'd0, 32'h0);

        // Compare with auto-reload and interrupt
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd5);
        wr(3'd1, 32'h3);
        wr(3'd0, 32'h07);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            idle();
            seen = irq;
        end
        check("irq_match_seen", {31'b0, seen}, 32'h1);
        rd(3'd2); check("autoreload_count", dout0, 32'd0);
        rd(3'd1); check("match_flag", dout0, 32'h1);
        wr(3'd1, 32'h1); check("irq_cleared", {31'b0, irq}, 32'h0);
        wr(3'd0, 32'h0);

        // Overflow from COUNT near max
        wr(3'd1, 32'h3);
        wr(3'd2, 32'hFFFFFFFE);
        wr(3'd3, 32'h0);
        wr(3'd0, 32'h05);
        idle();
        wr(3'd0, 32'h04);
        check("ovf_irq", {31'b0, irq}, 32'h1);
        rd(3'd2); check("ovf_count", dout0, 32'h0);
        rd(3'd1); check("ovf_status", dout0, 32'h2);

        // Byte masks
        wrm(3'd3, 32'hAABBCCDD, 4'b0000);
        wrm(3'd3, 32'h11223344, 4'b0101);
        rd(3'd3); check("byte_mask", dout0, 32'hAA22CC44);

        // Collisions: COUNT write vs tick, W1C vs MATCH set
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h3);
        wr(3'd3, 32'd1000);
        wr(3'd2, 32'd0);
        wr(3'd0, 32'h01);
        idle();
        wr(3'd2, 32'd100);
        rd(3'd2); check("count_write_wins", dout0, 32'd100);
        rd(3'd2); check("count_after_write", dout0, 32'd101);
        wr(3'd3, 32'd50);
        wr(3'd2, 32'd50);
        wr(3'd1, 32'h3);
        rd(3'd1); check("set_beats_w1c", dout0, 32'h1);
        wr(3'd0, 32'h05);
        check("irq_before_reset", {31'b0, irq}, 32'h1);

        // Asynchronous reset mid-count
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_dout", dout0, 32'h0);
        check("async_reset_irq", {31'b0, irq}, 32'h0);
        model_reset();
        #3 rst_n = 1'b1;
        idle();
        idle();
        rd(3'd2); check("count_after_reset", dout0, 32'h0);
        rd(3'd0); check("ctrl_after_reset", dout0, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            c = ($urandom_range(0, 3) == 0);
            w = 1'($urandom_range(0, 1));
            a = 3'($urandom_range(0, 7));
            m = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            d = $urandom;
            case (a)
                3'd0: begin
                    d[15:8] = 8'($urandom_range(0, 3));
                    d[0]    = ($urandom_range(0, 4) != 0);
                end
                3'd2: begin
                    m = 4'b0000;
                    d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20))
                                                   : 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
                end
                3'd3: begin
                    m = 4'b0000;
                    d = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(0, 20));
                end
                default: ;
            endcase
            access(c, w, m, a, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
